// File: rtl/hw_indicator_sched.sv
// ---------------------------------------------------------------------------
// hw_indicator_sched
//
// Lets several hardware status sources share one board LED. When no source
// is requesting, the LED shows a heartbeat that toggles every HB_MS ticks.
// When a source requests, the LED is granted to the lowest requesting index k.
// It then plays a blink code of k+1 pulses (ON_MS lit, OFF_MS dark between
// pulses), followed by a GAP_MS dark gap, before arbitrating again.
//
// Optional feature (macro HW_INDICATOR_PREEMPT_EN):
//   When the macro is defined, a request from an index lower than the current
//   owner aborts the pattern during ON/OFF. The pattern drops straight into
//   the gap and no completion pulse is produced.
//   When the macro is undefined, every granted pattern runs to completion.
//
// Parameters:
//   FREQ, TICK_HZ : clock and timebase rates; FREQ/TICK_HZ must be >= 2
//   NREQ          : number of requesters, 1..8
//   ON_MS, OFF_MS, GAP_MS, HB_MS : phase lengths in ticks, each >= 1
//
// Ports:
//   iCLK    in   clock
//   iRST_n  in   asynchronous active-low reset
//   iREQ    in   [NREQ] level requests (same clock domain), sampled in IDLE
//   oLED    out  registered LED drive, 1 = lit
//   oGRANT  out  [NREQ] one-hot current owner, 0 in IDLE
//   oDONE   out  [NREQ] one-cycle one-hot pulse when a pattern completes
//   oBUSY   out  high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module hw_indicator_sched #(
  parameter int FREQ    = 125000000,
  parameter int TICK_HZ = 1000,
  parameter int NREQ    = 4,
  parameter int ON_MS   = 200,
  parameter int OFF_MS  = 300,
  parameter int GAP_MS  = 1500,
  parameter int HB_MS   = 500
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  input  logic [NREQ-1:0] iREQ,
  output logic            oLED,
  output logic [NREQ-1:0] oGRANT,
  output logic [NREQ-1:0] oDONE,
  output logic            oBUSY
);

  localparam int TICK_DIV = FREQ / TICK_HZ;
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Terminal values: a phase of X ticks ends on the tick where tick_cnt == X-1.
  localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);
  localparam logic [31:0] ON_LAST  = 32'(ON_MS - 1);
  localparam logic [31:0] OFF_LAST = 32'(OFF_MS - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP_MS - 1);
  localparam logic [31:0] HB_LAST  = 32'(HB_MS - 1);

  localparam logic [NREQ-1:0] GRANT_ONE = NREQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [31:0]       presc_r;
  logic [31:0]       tick_cnt_r;
  logic [31:0]       blink_r;
  logic              led_r;
  logic [NREQ-1:0]   grant_r;
  logic [NREQ-1:0]   done_r;
  logic              busy_r;

  logic              tick_s;
  logic              req_any_s;
  logic [IW-1:0]     req_idx_s;
  logic              preempt_s;

  // Lowest set request index; index 0 has the highest priority.
  function automatic logic [IW-1:0] lowest_idx(input logic [NREQ-1:0] req);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
      end
    end
    return idx;
  endfunction

  assign tick_s    = (presc_r == DIV_LAST);
  assign req_any_s = |iREQ;
  assign req_idx_s = lowest_idx(iREQ);

`ifdef HW_INDICATOR_PREEMPT_EN
  // grant_r is one-hot, so grant_r - 1 masks exactly the indices below the owner.
  assign preempt_s = |(iREQ & (grant_r - GRANT_ONE));
`else
  assign preempt_s = 1'b0;
`endif

  // Scheduler FSM with timebase and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_r    <= ST_IDLE;
      presc_r    <= 32'd0;
      tick_cnt_r <= 32'd0;
      blink_r    <= 32'd0;
      led_r      <= 1'b1;
      grant_r    <= '0;
      done_r     <= '0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= '0;

      // Free-running timebase; phase changes below override it with a restart.
      if (tick_s) begin
        presc_r    <= 32'd0;
        tick_cnt_r <= tick_cnt_r + 32'd1;
      end else begin
        presc_r    <= presc_r + 32'd1;
      end

      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            // Arbitration ignores the heartbeat phase entirely.
            state_r    <= ST_ON;
            grant_r    <= GRANT_ONE << req_idx_s;
            blink_r    <= 32'(req_idx_s) + 32'd1;
            led_r      <= 1'b1;
            busy_r     <= 1'b1;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
          end else if (tick_s && (tick_cnt_r == HB_LAST)) begin
            led_r      <= ~led_r;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
          end else begin
            state_r    <= ST_IDLE;
          end
        end

        ST_ON: begin
          if (preempt_s) begin
            state_r    <= ST_GAP;
            led_r      <= 1'b0;
            grant_r    <= '0;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
          end else if (tick_s && (tick_cnt_r == ON_LAST)) begin
            led_r      <= 1'b0;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
            if (blink_r == 32'd1) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_OFF;
              blink_r <= blink_r - 32'd1;
            end
          end else begin
            state_r    <= ST_ON;
          end
        end

        ST_OFF: begin
          if (preempt_s) begin
            state_r    <= ST_GAP;
            led_r      <= 1'b0;
            grant_r    <= '0;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
          end else if (tick_s && (tick_cnt_r == OFF_LAST)) begin
            state_r    <= ST_ON;
            led_r      <= 1'b1;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
          end else begin
            state_r    <= ST_OFF;
          end
        end

        ST_GAP: begin
          if (tick_s && (tick_cnt_r == GAP_LAST)) begin
            // A preempted pattern already cleared grant_r, so it reports no completion.
            state_r    <= ST_IDLE;
            done_r     <= grant_r;
            grant_r    <= '0;
            led_r      <= 1'b1;
            busy_r     <= 1'b0;
            presc_r    <= 32'd0;
            tick_cnt_r <= 32'd0;
          end else begin
            state_r    <= ST_GAP;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          grant_r    <= '0;
          led_r      <= 1'b1;
          busy_r     <= 1'b0;
          presc_r    <= 32'd0;
          tick_cnt_r <= 32'd0;
        end
      endcase
    end
  end

  assign oLED   = led_r;
  assign oGRANT = grant_r;
  assign oDONE  = done_r;
  assign oBUSY  = busy_r;

endmodule

// File: tb/tb_hw_indicator_sched.sv
// ---------------------------------------------------------------------------
// Testbench for hw_indicator_sched with FREQ=1000, TICK_HZ=100 (10 cycles per
// tick), ON=2, OFF=2, GAP=5, HB=5 and NREQ=4.
//
// The reference model tracks the position within a pattern in cycles. It
// derives the LED from the pulse arithmetic: a period of 40 cycles, with the
// first 20 lit. Directed hand-computed checks pin key instants.
// ---------------------------------------------------------------------------
module tb_hw_indicator_sched;

  localparam int DIV     = 10;
  localparam int ON_CYC  = 2 * DIV;
  localparam int OFF_CYC = 2 * DIV;
  localparam int GAP_CYC = 5 * DIV;
  localparam int HB_CYC  = 5 * DIV;
`ifdef HW_INDICATOR_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       led;
  logic [3:0] grant;
  logic [3:0] done;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  hw_indicator_sched #(
    .FREQ(1000), .TICK_HZ(100), .NREQ(4),
    .ON_MS(2), .OFF_MS(2), .GAP_MS(5), .HB_MS(5)
  ) dut (
    .iCLK(clk), .iRST_n(rst_n), .iREQ(req),
    .oLED(led), .oGRANT(grant), .oDONE(done), .oBUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy = 1'b0;
  bit         m_pre  = 1'b0;
  int         m_k    = 0;
  int         m_pos  = 0;
  int         m_gap_from = 0;
  int         m_hb   = 0;
  logic [3:0] m_done = 4'b0000;

  function automatic int lowest(input logic [3:0] r);
    int idx;
    idx = 0;
    for (int i = 3; i >= 0; i--) if (r[i]) idx = i;
    return idx;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 1'b0; m_pre = 1'b0; m_hb = 0; m_done = 4'b0000; m_pos = 0;
      end else begin
        int pulse_end;
        int gap_start;
        m_done = 4'b0000;
        if (!m_busy) begin
          if (req != 4'b0000) begin
            m_k = lowest(req); m_busy = 1'b1; m_pos = 0; m_pre = 1'b0;
          end else begin
            m_hb++;
          end
        end else begin
          pulse_end = (m_k + 1) * ON_CYC + m_k * OFF_CYC;
          if (PREEMPT && !m_pre && (m_pos < pulse_end) &&
              ((req & ((4'b0001 << m_k) - 4'b0001)) != 4'b0000)) begin
            m_pre = 1'b1;
            m_gap_from = m_pos + 1;
          end
          m_pos++;
          gap_start = m_pre ? m_gap_from : pulse_end;
          if (m_pos == gap_start + GAP_CYC) begin
            m_busy = 1'b0;
            m_hb   = 0;
            m_done = m_pre ? 4'b0000 : (4'b0001 << m_k);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        logic       e_led;
        logic [3:0] e_grant;
        int         pulse_end;
        if (!m_busy) begin
          e_led   = ((m_hb / HB_CYC) % 2) == 0;
          e_grant = 4'b0000;
        end else begin
          pulse_end = (m_k + 1) * ON_CYC + m_k * OFF_CYC;
          e_led   = !m_pre && (m_pos < pulse_end) && ((m_pos % (ON_CYC + OFF_CYC)) < ON_CYC);
          e_grant = m_pre ? 4'b0000 : (4'b0001 << m_k);
        end
        check("model_led",   32'(led),   32'(e_led));
        check("model_grant", 32'(grant), 32'(e_grant));
        check("model_done",  32'(done),  32'(m_done));
        check("model_busy",  32'(busy),  32'(m_busy));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit, output int cycles, output logic [3:0] d);
    cycles = 0;
    d = 4'b0000;
    while ((cycles < limit) && (d == 4'b0000)) begin
      step(1);
      cycles++;
      d = done;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    logic [3:0] d;

    // 1. Reset values, then idle heartbeat every 50 cycles.
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;
    check("rst_led",   32'(led),   32'd1);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(49);
    check("hb_49_led", 32'(led), 32'd1);
    step(1);
    check("hb_50_led", 32'(led), 32'd0);
    check("hb_50_busy", 32'(busy), 32'd0);
    step(50);
    check("hb_100_led", 32'(led), 32'd1);

    // 2. Single-cycle request on index 2: three pulses then gap, done after 150.
    step(7);
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_busy",  32'(busy),  32'd1);
    check("t2_led0",  32'(led),   32'd1);
    step(19);
    check("t2_led19", 32'(led), 32'd1);
    step(1);
    check("t2_led20", 32'(led), 32'd0);
    step(80);
    check("t2_led100", 32'(led), 32'd0);
    step(49);
    check("t2_done149", 32'(done), 32'h0);
    step(1);
    check("t2_done150",  32'(done),  32'h4);
    check("t2_led150",   32'(led),   32'd1);
    check("t2_grant150", 32'(grant), 32'h0);
    step(1);
    check("t2_done151", 32'(done), 32'h0);

    // 3. Held 1010: index 1 first, then index 3 once index 1 drops on its done.
    step(13);
    req = 4'b1010;
    step(1);
    check("t3_grant_a", 32'(grant), 32'h2);
    wait_done(400, c, d);
    check("t3_done_a", 32'(d), 32'h2);
    check("t3_len_a",  32'(c), 32'd110);
    req = 4'b1000;
    step(1);
    check("t3_grant_b", 32'(grant), 32'h8);
    wait_done(400, c, d);
    check("t3_done_b", 32'(d), 32'h8);
    check("t3_len_b",  32'(c), 32'd190);
    req = 4'b0000;

    // 4/5. Index 0 requests while index 2 is in its first OFF phase.
    step(20);
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    check("t4_grant2", 32'(grant), 32'h4);
    step(30);
    req = 4'b0001;
    step(1);
    check("t4_busy31", 32'(busy), 32'd1);
    check("t4_led31",  32'(led),  32'd0);
    if (PREEMPT) begin
      check("t5_grant31", 32'(grant), 32'h0);
      step(50);
      check("t5_busy81",  32'(busy), 32'd0);
      check("t5_done81",  32'(done), 32'h0);
    end else begin
      check("t4_grant31", 32'(grant), 32'h4);
      wait_done(400, c, d);
      check("t4_done2",   32'(d), 32'h4);
      check("t4_len2",    32'(c), 32'd119);
    end
    step(1);
    check("t4_grant0", 32'(grant), 32'h1);
    check("t4_led_g0", 32'(led),   32'd1);
    req = 4'b0000;
    step(20);
    check("t4_led_p20", 32'(led), 32'd0);
    wait_done(400, c, d);
    check("t4_done0", 32'(d), 32'h1);
    check("t4_len0",  32'(c), 32'd50);

    // 6. Asynchronous reset during ON, then heartbeat from phase 0.
    step(9);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    step(5);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_led",   32'(led),   32'd1);
    check("t6_rst_grant", 32'(grant), 32'h0);
    check("t6_rst_busy",  32'(busy),  32'd0);
    check("t6_rst_done",  32'(done),  32'h0);
    step(2);
    @(negedge clk);
    rst_n = 1'b1;
    step(49);
    check("t6_hb49", 32'(led), 32'd1);
    step(1);
    check("t6_hb50", 32'(led), 32'd0);
    step(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
